ycr_pipe_mprf_mp: RTL

//  Parametrised multi-port register file for ycr pipelines: NRD read ports, NWR write ports,

---
 rtl/ycr_pipe_mprf_mp_pkg.sv | 32 +++
 rtl/ycr_pipe_mprf_mp_if.sv | 24 ++
 rtl/ycr_pipe_mprf_mp_rd_port.sv | 43 ++++
 rtl/ycr_pipe_mprf_mp.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ycr_pipe_mprf_mp_pkg.sv
// Shared types and helpers for the ycr multi-port register file.
// Holds the FSM encoding, the a0 index and the write-arbitration helper.
package ycr_mprf_pkg;

   localparam int MPRF_MAX_NWR = 2;
   localparam int MPRF_WIN_W   = 1;
   localparam int MPRF_RET_IDX = 10;

   typedef logic [0:0] mprf_state_e;
   localparam mprf_state_e MPRF_INIT = 1'b0;
   localparam mprf_state_e MPRF_RUN  = 1'b1;

   typedef struct packed {
      logic                  hit;
      logic [MPRF_WIN_W-1:0] idx;
   } mprf_win_t;

   // Highest-indexed matching write port wins, same rule as the storage commit.
   function automatic mprf_win_t mprf_win(input logic [MPRF_MAX_NWR-1:0] match);
      mprf_win_t r;
      r.hit = 1'b0;
      r.idx = '0;
      for (int i = 0; i < MPRF_MAX_NWR; i++) begin
         if (match[i]) begin
            r.hit = 1'b1;
            r.idx = MPRF_WIN_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ycr_pipe_mprf_mp_if.sv
// Read/write bus between the EXU (master) and the register file (slave).
// Handshake: no valid/ready; a write commits at posedge whenever wr_req_i[w] is set.
interface ycr_pipe_mprf_mp_if #(
   parameter int XLEN   = 32,
   parameter int AWIDTH = 5,
   parameter int NRD    = 2,
   parameter int NWR    = 1
);
   logic [NRD*AWIDTH-1:0] rd_addr_i;
   logic [NRD*XLEN-1:0]   rd_data_o;
   logic [NWR-1:0]        wr_req_i;
   logic [NWR*AWIDTH-1:0] wr_addr_i;
   logic [NWR*XLEN-1:0]   wr_data_i;

   modport master (
      output rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
      input  rd_data_o
   );

   modport slave (
      input  rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
      output rd_data_o
   );
endinterface

// File: rtl/ycr_pipe_mprf_mp_rd_port.sv
// One register-file read port: x0 mask, zero during clear, optional output stage
// with write-first bypass from the winning write port.
module ycr_mprf_rd_port #(
   parameter int XLEN     = 32,
   parameter int AWIDTH   = 5,
   parameter int RD_STAGE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              busy,
   input  logic [AWIDTH-1:0] rd_addr,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              byp_hit,
   input  logic [XLEN-1:0]   byp_data,
   output logic [XLEN-1:0]   rd_data
);

   generate
      if (RD_STAGE != 0) begin : g_stage
         logic [XLEN-1:0] data_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               data_q <= '0;
            end else if (busy || (rd_addr == '0)) begin
               data_q <= '0;
            end else if (byp_hit) begin
               data_q <= byp_data;
            end else begin
               data_q <= mem_data;
            end
         end

         assign rd_data = busy ? '0 : data_q;
      end else begin : g_comb
         logic unused_byp;
         assign unused_byp = ^{clk, rst, byp_hit, byp_data};
         // Read-before-write: a same-cycle write only shows up after the commit edge.
         assign rd_data = (busy || (rd_addr == '0)) ? '0 : mem_data;
      end
   endgenerate

endmodule

// File: rtl/ycr_pipe_mprf_mp.sv
// Multi-port integer register file: storage, write arbitration, collision flag
// and the post-reset clear FSM that zeroes x1..x(SIZE-1) one entry per cycle.
module ycr_pipe_mprf_mp
   import ycr_mprf_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int AWIDTH   = 5,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int RD_STAGE = 1,
   parameter int INIT_EN  = 1
) (
   input  logic                clk,
   input  logic                rst,
   ycr_pipe_mprf_mp_if.slave   bus,
   output logic                init_busy_o,
   output logic                wr_collision_o,
   output logic [XLEN-1:0]     func_return_val_o,
   output mprf_state_e         state_o
);

   localparam int SIZE = 2 ** AWIDTH;

   logic [XLEN-1:0]   mprf [SIZE];
   mprf_state_e       state;
   logic [AWIDTH-1:0] clr_ptr;
   logic              coll_q;
   logic              coll;

   logic [AWIDTH-1:0] wr_addr  [NWR];
   logic [XLEN-1:0]   wr_data  [NWR];
   logic [NWR-1:0]    wr_valid;

   assign init_busy_o = (state == MPRF_INIT);
   assign state_o     = state;

   for (genvar w = 0; w < NWR; w++) begin : g_wr
      assign wr_addr[w]  = bus.wr_addr_i[w*AWIDTH +: AWIDTH];
      assign wr_data[w]  = bus.wr_data_i[w*XLEN +: XLEN];
      assign wr_valid[w] = bus.wr_req_i[w] && (wr_addr[w] != '0) && (state == MPRF_RUN);

      always @(posedge clk) begin
         if (!rst && bus.wr_req_i[w] && (state == MPRF_RUN)) begin
            assert (!$isunknown({bus.wr_addr_i[w*AWIDTH +: AWIDTH], bus.wr_data_i[w*XLEN +: XLEN]}))
               else $error("mprf: unknown address/data on write port %0d", w);
         end
      end
   end

   always_comb begin
      coll = 1'b0;
      for (int i = 0; i < NWR; i++) begin
         for (int j = i + 1; j < NWR; j++) begin
            if (wr_valid[i] && wr_valid[j] && (wr_addr[i] == wr_addr[j])) begin
               coll = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= (INIT_EN != 0) ? MPRF_INIT : MPRF_RUN;
         clr_ptr <= AWIDTH'(1);
         coll_q  <= 1'b0;
      end else begin
         coll_q <= coll;
         if (state == MPRF_INIT) begin
            clr_ptr <= clr_ptr + AWIDTH'(1);
            if (clr_ptr == AWIDTH'(SIZE - 1)) begin
               state <= MPRF_RUN;
            end
         end
      end
   end

   assign wr_collision_o = coll_q;

   // Storage has no reset of its own; the clear FSM owns the write port while busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == MPRF_INIT) begin
            mprf[clr_ptr] <= '0;
         end else begin
            for (int w = 0; w < NWR; w++) begin
               if (wr_valid[w]) begin
                  mprf[wr_addr[w]] <= wr_data[w];
               end
            end
         end
      end
   end

   assign func_return_val_o = init_busy_o ? '0 : mprf[AWIDTH'(MPRF_RET_IDX)];

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AWIDTH-1:0]       rd_addr;
      logic [MPRF_MAX_NWR-1:0] match;
      mprf_win_t               win;
      logic [XLEN-1:0]         byp_data;

      assign rd_addr = bus.rd_addr_i[p*AWIDTH +: AWIDTH];

      always_comb begin
         match = '0;
         for (int w = 0; w < NWR; w++) begin
            match[w] = wr_valid[w] && (wr_addr[w] == rd_addr);
         end
         win      = mprf_win(match);
         byp_data = '0;
         for (int w = 0; w < NWR; w++) begin
            if (MPRF_WIN_W'(w) == win.idx) begin
               byp_data = wr_data[w];
            end
         end
      end

      ycr_mprf_rd_port #(
         .XLEN     (XLEN),
         .AWIDTH   (AWIDTH),
         .RD_STAGE (RD_STAGE)
      ) u_rd_port (
         .clk      (clk),
         .rst      (rst),
         .busy     (init_busy_o),
         .rd_addr  (rd_addr),
         .mem_data (mprf[rd_addr]),
         .byp_hit  (win.hit),
         .byp_data (byp_data),
         .rd_data  (bus.rd_data_o[p*XLEN +: XLEN])
      );
   end

endmodule
